// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared types and widths for the iterative restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DIV_W = 3;
    localparam int CNT_W = $clog2(2 * DIV_W + 1);

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational restoring-division step (shift in a bit, trial subtract).
module div_step
    import seq_divider_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W-1:0] r_in,
    input  logic         bit_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] r_out,
    output logic         q_bit
);

    logic [W:0] shifted;
    logic [W:0] diff;

    // The W+1-bit trial value; only its low W bits survive to the next step.
    assign shifted = {r_in, bit_in};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = shifted >= {1'b0, divisor};
    assign r_out   = q_bit ? diff[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/seq_divider.sv
// seq_divider: 2W/W unsigned restoring divider, one quotient bit per clock.
// Optional SEQ_DIVIDER_DBZ_EN: zero divisor finishes at once and raises dbz.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] quotient,
    output logic [W-1:0]   remainder,
    output logic           dbz
);

    localparam int CW = $clog2(2 * W + 1);

    state_t         state;
    state_t         state_nx;
    logic [2*W-1:0] dvd;
    logic [W-1:0]   dvs;
    logic [W-1:0]   r;
    logic [W-1:0]   r_nx;
    logic           q_bit;
    logic [CW-1:0]  cnt;
    logic           accept;
    logic           last;
    logic           zero_div;

    assign accept = start && (state != RUN);
    assign last   = cnt == CW'(2 * W - 1);
    assign busy   = state == RUN;
    assign done   = state == DONE;

`ifdef SEQ_DIVIDER_DBZ_EN
    logic dbz_q;
    assign zero_div = divisor == '0;
    assign dbz      = dbz_q;
`else
    assign zero_div = 1'b0;
    assign dbz      = 1'b0;
`endif

    div_step #(.W(W)) u_step (
        .r_in    (r),
        .bit_in  (dvd[2*W-1]),
        .divisor (dvs),
        .r_out   (r_nx),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) state_nx = zero_div ? DONE : RUN;
                else       state_nx = IDLE;
            end
            RUN:     if (last) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // dvd doubles as the quotient shift register: dividend bits leave at
    // the top while quotient bits enter at the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd       <= '0;
            dvs       <= '0;
            r         <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef SEQ_DIVIDER_DBZ_EN
            dbz_q     <= 1'b0;
`endif
        end else if (accept) begin
            dvd <= dividend;
            dvs <= divisor;
            r   <= '0;
            cnt <= '0;
            if (zero_div) begin
                quotient  <= '1;
                remainder <= dividend[W-1:0];
`ifdef SEQ_DIVIDER_DBZ_EN
                dbz_q     <= 1'b1;
`endif
            end
        end else if (state == RUN) begin
            dvd <= {dvd[2*W-2:0], q_bit};
            r   <= r_nx;
            cnt <= cnt + 1'b1;
            if (last) begin
                quotient  <= {dvd[2*W-2:0], q_bit};
                remainder <= r_nx;
`ifdef SEQ_DIVIDER_DBZ_EN
                dbz_q     <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider (W=3) with directed vectors.
module tb_seq_divider;
    import seq_divider_pkg::*;

    localparam int W = DIV_W;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [2*W-1:0] dividend = '0;
    logic [W-1:0]   divisor = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] quotient;
    logic [W-1:0]   remainder;
    logic           dbz;

    seq_divider #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [2*W-1:0] q;
        logic [W-1:0]   r;
        logic           z;
        int             at;
    } exp_t;

    exp_t           sb[$];
    int             errors = 0;
    int             checks = 0;
    int             dones = 0;
    logic [2*W-1:0] last_q = '0;
    logic [W-1:0]   last_r = '0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, need %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pop an expectation for every done, check hold while busy.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                dones++;
                if (sb.size() == 0) begin
                    chk("spurious_done", int'(done), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("quotient", int'(quotient), int'(e.q));
                    chk("remainder", int'(remainder), int'(e.r));
                    chk("dbz", int'(dbz), int'(e.z));
                    chk("done_cycle", cyc, e.at);
                    last_q = e.q;
                    last_r = e.r;
                end
            end else if (busy) begin
                chk("hold_quotient", int'(quotient), int'(last_q));
                chk("hold_remainder", int'(remainder), int'(last_r));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2*W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] q, input logic [W-1:0] r,
                         input logic z, input int lat);
        exp_t e;
        e.q  = q;
        e.r  = r;
        e.z  = z;
        e.at = cyc + 1 + lat;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        if (lat > 0) chk("busy_after_start", int'(busy), 1);
        else         chk("done_after_start", int'(done), 1);
    endtask

    task automatic wait_done();
        for (int n = 0; n < 30; n++) begin
            if (done) return;
            @(negedge clk);
        end
        chk("wait_done_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 40; n++) begin
            if (sb.size() == 0 && !busy && !done) return;
            @(negedge clk);
        end
        chk("wait_idle_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_dbz", int'(dbz), 0);
        rst = 1'b0;
        @(negedge clk);

        issue(6'd10, 3'd2, 6'd5, 3'd0, 1'b0, 6);
        wait_idle();

        issue(6'd37, 3'd5, 6'd7, 3'd2, 1'b0, 6);
        wait_done();
        issue(6'd63, 3'd1, 6'd63, 3'd0, 1'b0, 6);
        wait_idle();

        issue(6'd45, 3'd6, 6'd7, 3'd3, 1'b0, 6);
        @(negedge clk);
        start    = 1'b1;
        dividend = 6'd20;
        divisor  = 3'd3;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

`ifdef SEQ_DIVIDER_DBZ_EN
        issue(6'd45, 3'd0, 6'd63, 3'd5, 1'b1, 0);
`else
        issue(6'd45, 3'd0, 6'd63, 3'd5, 1'b0, 6);
`endif
        wait_idle();

        // Division killed by reset: no expectation is queued for it.
        start    = 1'b1;
        dividend = 6'd63;
        divisor  = 3'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_quotient", int'(quotient), 0);
        chk("midrst_remainder", int'(remainder), 0);
        chk("midrst_dbz", int'(dbz), 0);
        last_q = '0;
        last_r = '0;
        rst    = 1'b0;
        repeat (8) @(negedge clk);

        issue(6'd63, 3'd7, 6'd9, 3'd0, 1'b0, 6);
        wait_idle();
        repeat (3) @(negedge clk);

        chk("scoreboard_empty", sb.size(), 0);
        chk("done_count", dones, 6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
